// File: rtl/sdrd_fat32_pkg.sv
// Shared FAT32 constants, read-type encodings and cluster-walker state encoding
// for the SD read path.
package sdrd_fat32_pkg;

  typedef enum logic [1:0] {
    RD_BPB  = 2'b00,
    RD_DIR  = 2'b01,
    RD_FAT  = 2'b10,
    RD_DATA = 2'b11
  } rd_type_e;

  localparam logic [31:0] CLUS_MASK       = 32'h0FFF_FFFF;
  localparam logic [27:0] EOC_MIN         = 28'hFFF_FFF8;
  localparam logic [27:0] BAD_CLUS        = 28'hFFF_FFF7;
  localparam logic [27:0] FIRST_DATA_CLUS = 28'd2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WAIT_ENTRY,
    ST_CHECK,
    ST_DATA_REQ,
    ST_DATA_WAIT,
    ST_FAT_REQ,
    ST_FAT_WAIT,
    ST_DONE,
    ST_ERR
  } walk_state_e;

  // Sectors per cluster from its log2; 7 gives 128, which still fits 8 bits.
  function automatic logic [7:0] spc_of(input logic [2:0] spc_log2);
    return 8'd1 << spc_log2;
  endfunction

endpackage

// File: rtl/sdrd_clus2lba.sv
// Combinational cluster-to-LBA mapping: data sector LBA within a cluster and the
// FAT sector/word holding that cluster's chain entry.
module sdrd_clus2lba
  import sdrd_fat32_pkg::*;
(
  input  logic [27:0] CLUS,
  input  logic [7:0]  SEC,
  input  logic [2:0]  SPC_LOG2,
  input  logic [31:0] FAT_BEGIN_LBA,
  input  logic [31:0] CLUS_BEGIN_LBA,
  output logic [31:0] DATA_LBA,
  output logic [31:0] FAT_LBA,
  output logic [6:0]  FAT_OFS
);

  logic [27:0] rel_clus;

  // 128 four-byte FAT entries per 512-byte sector.
  assign rel_clus = CLUS - FIRST_DATA_CLUS;
  assign DATA_LBA = CLUS_BEGIN_LBA + ({4'd0, rel_clus} << SPC_LOG2) + {24'd0, SEC};
  assign FAT_LBA  = FAT_BEGIN_LBA + {11'd0, CLUS[27:7]};
  assign FAT_OFS  = CLUS[6:0];

endmodule

// File: rtl/sdrd_cluster_walker.sv
// Walks one picture's FAT32 cluster chain at a time, issuing data-sector reads
// for every sector of each cluster and a FAT read to find the next cluster.
module sdrd_cluster_walker
  import sdrd_fat32_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYC = 24'd4000000,
  parameter int          TOW         = 22
) (
  input  logic        CLK,
  input  logic        RST_X,
  input  logic        SPI_INIT,
  input  logic        BPB_VALID,
  input  logic [2:0]  SPC_LOG2,
  input  logic [31:0] FAT_BEGIN_LBA,
  input  logic [31:0] CLUS_BEGIN_LBA,
  input  logic        PICENTRY_EMPTY,
  input  logic [31:0] PICENTRY_DATA,
  output logic        PICENTRY_RD,
  input  logic        NEXT_PIC,
  input  logic        DATABUF_AFULL,
  output logic        RD_REQ,
  output logic [31:0] RD_ADR,
  output logic [1:0]  RD_TYPE,
  output logic [6:0]  RD_OFS,
  input  logic        RD_ACK,
  input  logic        RD_DONE,
  input  logic [31:0] RD_WORD,
  output logic        PIC_START,
  output logic        PIC_DONE,
  output logic        WALK_ERR
);

  localparam logic [TOW-1:0] TO_LIM = TOW'(TIMEOUT_CYC);

  walk_state_e    state_reg, state_next;
  logic [27:0]    clus_reg;
  logic [7:0]     sec_reg;
  logic           req_on_reg;
  logic           first_reg;
  logic           pic_done_reg;
  logic [TOW-1:0] to_cnt_reg;

  logic        abort;
  logic        done_ev;
  logic        timed_out;
  logic        last_sec;
  logic [7:0]  sec_inc;
  logic [31:0] data_lba;
  logic [31:0] fat_lba;
  logic [6:0]  fat_ofs;

  // A dropped BPB is as fatal as a card re-init, except that an error stays
  // visible until SPI_INIT explicitly clears it.
  assign abort     = SPI_INIT | (~BPB_VALID & (state_reg != ST_IDLE) & (state_reg != ST_ERR));
  assign done_ev   = RD_DONE & ~RD_ACK;
  assign timed_out = (to_cnt_reg == TO_LIM);
  assign sec_inc   = sec_reg + 8'd1;
  assign last_sec  = (sec_inc == spc_of(SPC_LOG2));

  sdrd_clus2lba u_clus2lba (
    .CLUS           (clus_reg),
    .SEC            (sec_reg),
    .SPC_LOG2       (SPC_LOG2),
    .FAT_BEGIN_LBA  (FAT_BEGIN_LBA),
    .CLUS_BEGIN_LBA (CLUS_BEGIN_LBA),
    .DATA_LBA       (data_lba),
    .FAT_LBA        (fat_lba),
    .FAT_OFS        (fat_ofs)
  );

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:       if (BPB_VALID) state_next = ST_WAIT_ENTRY;
      ST_WAIT_ENTRY: if (!PICENTRY_EMPTY) state_next = ST_CHECK;
      ST_CHECK: begin
        if (clus_reg < FIRST_DATA_CLUS || clus_reg == BAD_CLUS) state_next = ST_ERR;
        else if (clus_reg >= EOC_MIN)                           state_next = ST_DONE;
        else                                                    state_next = ST_DATA_REQ;
      end
      ST_DATA_REQ:   if (req_on_reg && RD_ACK) state_next = ST_DATA_WAIT;
      ST_DATA_WAIT: begin
        if (done_ev)        state_next = last_sec ? ST_FAT_REQ : ST_DATA_REQ;
        else if (timed_out) state_next = ST_ERR;
      end
      ST_FAT_REQ:    if (RD_ACK) state_next = ST_FAT_WAIT;
      ST_FAT_WAIT: begin
        if (done_ev)        state_next = ST_CHECK;
        else if (timed_out) state_next = ST_ERR;
      end
      ST_DONE:       if (NEXT_PIC) state_next = ST_WAIT_ENTRY;
      ST_ERR:        state_next = ST_ERR;
      default:       state_next = ST_IDLE;
    endcase
    if (abort) state_next = ST_IDLE;
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      clus_reg     <= '0;
      sec_reg      <= '0;
      req_on_reg   <= 1'b0;
      first_reg    <= 1'b0;
      pic_done_reg <= 1'b0;
      to_cnt_reg   <= '0;
    end else if (abort) begin
      req_on_reg   <= 1'b0;
      first_reg    <= 1'b0;
      pic_done_reg <= 1'b0;
      to_cnt_reg   <= '0;
    end else begin
      pic_done_reg <= (state_reg == ST_CHECK) && (state_next == ST_DONE);
      case (state_reg)
        ST_WAIT_ENTRY: begin
          if (!PICENTRY_EMPTY) begin
            clus_reg  <= 28'(PICENTRY_DATA & CLUS_MASK);
            first_reg <= 1'b1;
          end
        end
        ST_CHECK: sec_reg <= '0;
        // Buffer space is judged once; after that the request is held until taken.
        ST_DATA_REQ: begin
          if (!req_on_reg) begin
            req_on_reg <= ~DATABUF_AFULL;
          end else if (RD_ACK) begin
            req_on_reg <= 1'b0;
            first_reg  <= 1'b0;
            to_cnt_reg <= '0;
          end
        end
        ST_DATA_WAIT: begin
          if (done_ev) sec_reg    <= sec_inc;
          else         to_cnt_reg <= to_cnt_reg + TOW'(1);
        end
        ST_FAT_REQ: if (RD_ACK) to_cnt_reg <= '0;
        ST_FAT_WAIT: begin
          if (done_ev) clus_reg   <= 28'(RD_WORD & CLUS_MASK);
          else         to_cnt_reg <= to_cnt_reg + TOW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    PICENTRY_RD = 1'b0;
    RD_REQ      = 1'b0;
    RD_ADR      = '0;
    RD_TYPE     = '0;
    RD_OFS      = '0;
    PIC_START   = 1'b0;
    PIC_DONE    = pic_done_reg;
    WALK_ERR    = (state_reg == ST_ERR);
    case (state_reg)
      ST_WAIT_ENTRY: PICENTRY_RD = ~PICENTRY_EMPTY & ~abort;
      ST_DATA_REQ: begin
        if (req_on_reg) begin
          RD_REQ    = 1'b1;
          RD_TYPE   = RD_DATA;
          RD_ADR    = data_lba;
          PIC_START = RD_ACK & first_reg & ~abort;
        end
      end
      ST_FAT_REQ: begin
        RD_REQ  = 1'b1;
        RD_TYPE = RD_FAT;
        RD_ADR  = fat_lba;
        RD_OFS  = fat_ofs;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sdrd_cluster_walker.sv
// Directed bench for sdrd_cluster_walker: FIFO and sector-engine responders,
// request log, and hand-computed expected LBAs per walk.
module tb_sdrd_cluster_walker;

  localparam logic [31:0] FAT_BEGIN  = 32'h0000_0100;
  localparam logic [31:0] CLUS_BEGIN = 32'h0000_2000;

  typedef struct {
    logic [1:0]  typ;
    logic [31:0] adr;
    logic [6:0]  ofs;
  } req_t;

  logic        CLK, RST_X, SPI_INIT, BPB_VALID;
  logic [2:0]  SPC_LOG2;
  logic [31:0] FAT_BEGIN_LBA, CLUS_BEGIN_LBA;
  logic        PICENTRY_EMPTY;
  logic [31:0] PICENTRY_DATA;
  logic        PICENTRY_RD, NEXT_PIC, DATABUF_AFULL, RD_REQ;
  logic [31:0] RD_ADR;
  logic [1:0]  RD_TYPE;
  logic [6:0]  RD_OFS;
  logic        RD_ACK, RD_DONE;
  logic [31:0] RD_WORD;
  logic        PIC_START, PIC_DONE, WALK_ERR;

  int tests_run = 0;
  int tests_failed = 0;
  int pic_start_cnt = 0;
  int pic_done_cnt = 0;
  int pop_cnt = 0;
  int req_hi_cnt = 0;
  int ack_delay = 0;
  int done_delay = 1;
  bit done_en = 1'b1;
  bit resp_kill = 1'b0;
  bit pop_pend;

  logic [31:0] pic_q[$];
  logic [31:0] fat_tbl[int];
  req_t        log_q[$];

  sdrd_cluster_walker #(.TIMEOUT_CYC(24'd100), .TOW(22)) dut (
    .CLK            (CLK),
    .RST_X          (RST_X),
    .SPI_INIT       (SPI_INIT),
    .BPB_VALID      (BPB_VALID),
    .SPC_LOG2       (SPC_LOG2),
    .FAT_BEGIN_LBA  (FAT_BEGIN_LBA),
    .CLUS_BEGIN_LBA (CLUS_BEGIN_LBA),
    .PICENTRY_EMPTY (PICENTRY_EMPTY),
    .PICENTRY_DATA  (PICENTRY_DATA),
    .PICENTRY_RD    (PICENTRY_RD),
    .NEXT_PIC       (NEXT_PIC),
    .DATABUF_AFULL  (DATABUF_AFULL),
    .RD_REQ         (RD_REQ),
    .RD_ADR         (RD_ADR),
    .RD_TYPE        (RD_TYPE),
    .RD_OFS         (RD_OFS),
    .RD_ACK         (RD_ACK),
    .RD_DONE        (RD_DONE),
    .RD_WORD        (RD_WORD),
    .PIC_START      (PIC_START),
    .PIC_DONE       (PIC_DONE),
    .WALK_ERR       (WALK_ERR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got still running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Main process acts 3 time units after each falling edge.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge CLK);
      #3;
    end
  endtask

  task automatic wait_pic_done(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (pic_done_cnt < target && n < budget) begin
      step(1);
      n++;
    end
    check_val(tag, pic_done_cnt, target);
  endtask

  task automatic wait_log(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (log_q.size() < target && n < budget) begin
      step(1);
      n++;
    end
    check_val(tag, log_q.size(), target);
  endtask

  task automatic wait_err(input string tag, input int budget);
    int n;
    n = 0;
    while (WALK_ERR !== 1'b1 && n < budget) begin
      step(1);
      n++;
    end
    check_val(tag, WALK_ERR, 1'b1);
  endtask

  task automatic check_req(input string tag, input int idx, input logic [1:0] typ,
                           input logic [31:0] adr, input logic [6:0] ofs, input bit chk_ofs);
    req_t r;
    if (idx < log_q.size()) begin
      r = log_q[idx];
    end else begin
      r.typ = 2'b00;
      r.adr = 32'hFFFF_FFFF;
      r.ofs = 7'h7F;
    end
    check_val($sformatf("%s[%0d].type", tag, idx), r.typ, typ);
    check_val($sformatf("%s[%0d].adr", tag, idx), r.adr, adr);
    if (chk_ofs) check_val($sformatf("%s[%0d].ofs", tag, idx), r.ofs, ofs);
  endtask

  // Four consecutive data sectors of one cluster (SPC_LOG2 = 2).
  task automatic check_data4(input string tag, input int idx, input logic [31:0] first_adr);
    for (int k = 0; k < 4; k++) check_req(tag, idx + k, 2'b11, first_adr + k, 7'd0, 1'b0);
  endtask

  task automatic spi_init_pulse();
    SPI_INIT  = 1'b1;
    resp_kill = 1'b1;
    step(1);
    SPI_INIT  = 1'b0;
  endtask

  task automatic next_pic_pulse();
    NEXT_PIC = 1'b1;
    step(1);
    NEXT_PIC = 1'b0;
  endtask

  // Sector engine: acks after ack_delay cycles of RD_REQ, then returns RD_DONE.
  initial begin
    int   phase;
    int   wait_cnt;
    int   done_cnt;
    int   key;
    req_t cur;
    phase = 0;
    wait_cnt = 0;
    done_cnt = 0;
    cur.typ = 2'b00;
    cur.adr = 32'h0;
    cur.ofs = 7'h0;
    RD_ACK = 1'b0;
    RD_DONE = 1'b0;
    RD_WORD = 32'h0;
    forever begin
      @(negedge CLK);
      RD_ACK = 1'b0;
      RD_DONE = 1'b0;
      if (resp_kill) begin
        phase = 0;
        wait_cnt = 0;
        resp_kill = 1'b0;
      end
      if (phase == 0) begin
        if (RD_REQ === 1'b1) begin
          if (wait_cnt >= ack_delay) begin
            cur.typ = RD_TYPE;
            cur.adr = RD_ADR;
            cur.ofs = RD_OFS;
            log_q.push_back(cur);
            $display("[TB] req type=%b adr=%08h ofs=%0d", cur.typ, cur.adr, cur.ofs);
            RD_ACK = 1'b1;
            phase = 1;
            wait_cnt = 0;
            done_cnt = 0;
          end else begin
            wait_cnt++;
          end
        end
      end else begin
        done_cnt++;
        if (done_en && done_cnt >= done_delay) begin
          RD_DONE = 1'b1;
          if (cur.typ == 2'b10) begin
            key = int'((cur.adr - FAT_BEGIN) * 32'd128 + {25'd0, cur.ofs});
            RD_WORD = fat_tbl.exists(key) ? fat_tbl[key] : 32'h0FFF_FFF7;
          end else begin
            RD_WORD = 32'h0;
          end
          phase = 0;
        end
      end
    end
  end

  // Picture-entry FIFO (FWFT) plus pulse counters.
  initial begin
    pop_pend = 1'b0;
    PICENTRY_EMPTY = 1'b1;
    PICENTRY_DATA = 32'h0;
    forever begin
      @(negedge CLK);
      if (pop_pend && pic_q.size() > 0) void'(pic_q.pop_front());
      pop_pend = 1'b0;
      PICENTRY_EMPTY = (pic_q.size() == 0);
      PICENTRY_DATA = (pic_q.size() > 0) ? pic_q[0] : 32'h0;
      #2;
      if (PICENTRY_RD === 1'b1) begin
        pop_pend = 1'b1;
        pop_cnt++;
      end
      if (PIC_START === 1'b1) pic_start_cnt++;
      if (PIC_DONE === 1'b1) pic_done_cnt++;
      if (RD_REQ === 1'b1) req_hi_cnt++;
    end
  end

  initial begin
    int snap;
    RST_X = 1'b0;
    SPI_INIT = 1'b0;
    BPB_VALID = 1'b1;
    SPC_LOG2 = 3'd2;
    FAT_BEGIN_LBA = FAT_BEGIN;
    CLUS_BEGIN_LBA = CLUS_BEGIN;
    NEXT_PIC = 1'b0;
    DATABUF_AFULL = 1'b0;
    step(3);
    check_val("rst_rd_req", RD_REQ, 1'b0);
    check_val("rst_walk_err", WALK_ERR, 1'b0);
    check_val("rst_pic_done", PIC_DONE, 1'b0);
    check_val("rst_pop", PICENTRY_RD, 1'b0);
    check_val("rst_rd_adr", RD_ADR, 32'h0);
    RST_X = 1'b1;
    step(2);

    // Single-cluster file at cluster 5.
    fat_tbl[5] = 32'h0FFF_FFFF;
    pic_q.push_back(32'h5);
    wait_pic_done("single_done", 1, 300);
    check_val("single_nreq", log_q.size(), 5);
    check_data4("single", 0, 32'h0000_200C);
    check_req("single", 4, 2'b10, 32'h0000_0100, 7'd5, 1'b1);
    check_val("single_pops", pop_cnt, 1);
    check_val("single_start", pic_start_cnt, 1);

    // Chain 0x7F -> 0x80 -> EOC, crossing a FAT sector boundary.
    log_q.delete();
    fat_tbl[32'h7F] = 32'h0000_0080;
    fat_tbl[32'h80] = 32'h0FFF_FFF8;
    pic_q.push_back(32'h7F);
    next_pic_pulse();
    wait_pic_done("chain_done", 2, 600);
    check_val("chain_nreq", log_q.size(), 10);
    check_data4("chain", 0, 32'h0000_21F4);
    check_req("chain", 4, 2'b10, 32'h0000_0100, 7'd127, 1'b1);
    check_data4("chain", 5, 32'h0000_21F8);
    check_req("chain", 9, 2'b10, 32'h0000_0101, 7'd0, 1'b1);
    check_val("chain_start", pic_start_cnt, 2);

    // Backpressure on cluster 3, then a withheld acknowledge.
    log_q.delete();
    fat_tbl[3] = 32'h0FFF_FFFF;
    DATABUF_AFULL = 1'b1;
    pic_q.push_back(32'h3);
    snap = req_hi_cnt;
    next_pic_pulse();
    step(50);
    check_val("bp_req_held_low", req_hi_cnt - snap, 0);
    check_val("bp_popped", pop_cnt, 3);
    ack_delay = 10;
    DATABUF_AFULL = 1'b0;
    check_val("bp_req_same_cycle", RD_REQ, 1'b0);
    step(1);
    check_val("bp_req_rise", RD_REQ, 1'b1);
    check_val("bp_adr_first", RD_ADR, 32'h0000_2004);
    step(9);
    check_val("bp_req_hold", RD_REQ, 1'b1);
    check_val("bp_adr_hold", RD_ADR, 32'h0000_2004);
    check_val("bp_no_ack_yet", log_q.size(), 0);
    wait_pic_done("bp_done", 3, 600);
    ack_delay = 0;
    check_data4("bp", 0, 32'h0000_2004);
    check_req("bp", 4, 2'b10, 32'h0000_0100, 7'd3, 1'b1);

    // Bad FAT link (cluster 1) stops the walk with an error.
    log_q.delete();
    fat_tbl[10] = 32'h0000_0001;
    pic_q.push_back(32'hA);
    next_pic_pulse();
    wait_err("faterr_flag", 300);
    check_data4("faterr", 0, 32'h0000_2020);
    check_req("faterr", 4, 2'b10, 32'h0000_0100, 7'd10, 1'b1);
    step(20);
    check_val("faterr_nreq", log_q.size(), 5);
    check_val("faterr_req_low", RD_REQ, 1'b0);
    check_val("faterr_sticky", WALK_ERR, 1'b1);
    check_val("faterr_no_done", pic_done_cnt, 3);
    spi_init_pulse();
    check_val("faterr_cleared", WALK_ERR, 1'b0);

    // Missing RD_DONE on cluster 2 runs into the 100-cycle timeout.
    log_q.delete();
    done_en = 1'b0;
    pic_q.push_back(32'h2);
    wait_log("to_req", 1, 100);
    check_req("to", 0, 2'b11, 32'h0000_2000, 7'd0, 1'b0);
    step(50);
    check_val("to_not_early", WALK_ERR, 1'b0);
    wait_err("to_flag", 150);
    spi_init_pulse();
    done_en = 1'b1;
    check_val("to_cleared", WALK_ERR, 1'b0);

    // SPI_INIT during DATA_WAIT, then restart from a fresh entry.
    log_q.delete();
    done_delay = 20;
    pic_q.push_back(32'h4);
    wait_log("abort_req", 1, 100);
    check_req("abort", 0, 2'b11, 32'h0000_2008, 7'd0, 1'b0);
    step(3);
    BPB_VALID = 1'b0;
    spi_init_pulse();
    check_val("abort_req_low", RD_REQ, 1'b0);
    check_val("abort_no_err", WALK_ERR, 1'b0);
    step(30);
    check_val("abort_nreq", log_q.size(), 1);
    check_val("abort_no_done", pic_done_cnt, 3);
    check_val("abort_pops", pop_cnt, 6);
    log_q.delete();
    done_delay = 1;
    fat_tbl[6] = 32'h0FFF_FFFF;
    pic_q.push_back(32'h6);
    BPB_VALID = 1'b1;
    wait_pic_done("restart_done", 4, 300);
    check_val("restart_nreq", log_q.size(), 5);
    check_data4("restart", 0, 32'h0000_2010);
    check_req("restart", 4, 2'b10, 32'h0000_0100, 7'd6, 1'b1);
    check_val("restart_start", pic_start_cnt, 7);

    // Empty file (start cluster is EOC), then NEXT_PIC pops cluster 7.
    log_q.delete();
    fat_tbl[7] = 32'h0FFF_FFFF;
    pic_q.push_back(32'h0FFF_FFFF);
    pic_q.push_back(32'h7);
    next_pic_pulse();
    wait_pic_done("empty_done", 5, 100);
    step(5);
    check_val("empty_nreq", log_q.size(), 0);
    check_val("empty_pops", pop_cnt, 8);
    check_val("empty_no_start", pic_start_cnt, 7);
    next_pic_pulse();
    wait_pic_done("after_empty_done", 6, 300);
    check_val("after_empty_pops", pop_cnt, 9);
    check_data4("after_empty", 0, 32'h0000_2014);
    check_req("after_empty", 4, 2'b10, 32'h0000_0100, 7'd7, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sdrd_cluster_walker.md
Name: sdrd_cluster_walker

Overview:
- Sequences the shared SD read engine through the FAT32 cluster chain of one picture file at a time.
- Pops a picture start cluster from the picture-entry FIFO and converts each cluster into data-sector LBAs.
- Issues one read request per sector, then fetches that cluster's FAT entry to find the next cluster, until end-of-chain.
- Sits between the FAT32 directory controller (entry FIFO, BPB values) and the SPI sector reader / picture data buffer.

Parameters:
- TIMEOUT_CYC, 24'd4000000, cycles allowed from request acknowledge to RD_DONE before ERR.
- TOW, 22, width of the timeout counter.

Ports:
- CLK  in  1  clock
- RST_X  in  1  reset
- SPI_INIT  in  1  card (re)initialising; aborts walk
- BPB_VALID  in  1  BPB fields below are stable and valid
- SPC_LOG2  in  3  log2(sectors per cluster), 0..7
- FAT_BEGIN_LBA  in  32  LBA of FAT #1
- CLUS_BEGIN_LBA  in  32  LBA of cluster 2
- PICENTRY_EMPTY  in  1  entry FIFO empty
- PICENTRY_DATA  in  32  start cluster of next picture (FWFT)
- PICENTRY_RD  out  1  pop strobe
- NEXT_PIC  in  1  pulse: display wants next picture
- DATABUF_AFULL  in  1  picture buffer cannot take another sector
- RD_REQ  out  1  sector read request
- RD_ADR  out  32  sector LBA
- RD_TYPE  out  2  2'b10 FAT, 2'b11 data
- RD_OFS  out  7  32-bit word index returned for FAT reads
- RD_ACK  in  1  engine accepted request (1 cycle)
- RD_DONE  in  1  sector finished (1 cycle)
- RD_WORD  in  32  selected word, valid with RD_DONE on FAT reads
- PIC_START  out  1  pulse: first data sector of a picture requested
- PIC_DONE  out  1  pulse: chain ended normally
- WALK_ERR  out  1  sticky error; cleared by SPI_INIT or reset

Behaviour:
- Reset RST_X: asynchronous, active-low. Clock CLK.
- Reset values: all outputs 0, state IDLE.
- States and transitions:
  - IDLE: go to WAIT_ENTRY when BPB_VALID & ~SPI_INIT.
  - WAIT_ENTRY: when ~PICENTRY_EMPTY, assert PICENTRY_RD for exactly one cycle and latch clus=PICENTRY_DATA[27:0]; go to CHECK.
  - CHECK: clus<2 or clus==0x0FFFFFF7 -> ERR; clus>=0x0FFFFFF8 -> DONE (empty file); else sec=0 -> DATA_REQ.
  - DATA_REQ: when ~DATABUF_AFULL, drive RD_REQ=1, RD_TYPE=11, RD_ADR=CLUS_BEGIN_LBA+((clus-2)<<SPC_LOG2)+sec. Hold all three until RD_ACK, then go to DATA_WAIT.
  - DATA_WAIT: on RD_DONE, sec+1; if sec+1 == 1<<SPC_LOG2 go to FAT_REQ, else DATA_REQ.
  - FAT_REQ: RD_REQ=1, RD_TYPE=10, RD_ADR=FAT_BEGIN_LBA+clus[27:7], RD_OFS=clus[6:0]. Hold until RD_ACK, then FAT_WAIT.
  - FAT_WAIT: on RD_DONE, clus=RD_WORD[27:0] (upper 4 bits ignored); go to CHECK.
  - DONE: PIC_DONE pulses one cycle on entry; wait for NEXT_PIC, then WAIT_ENTRY.
  - ERR: WALK_ERR=1; RD_REQ=0; stay until SPI_INIT.
- PIC_START: pulses on the RD_ACK cycle of the first data sector (sec=0 of the start cluster) only.
- RD_REQ never depends combinationally on RD_ACK. At most one outstanding request.
- DATABUF_AFULL is sampled only before asserting RD_REQ in DATA_REQ. Once RD_REQ is high it is not withdrawn.
- Timeout: counter clears on RD_ACK and counts in DATA_WAIT/FAT_WAIT. Reaching TIMEOUT_CYC -> ERR.
- Arithmetic:
  - (clus-2) is 28-bit; the shift result is truncated to 32 bits.
  - sec is 8 bits; SPC_LOG2=7 gives 128 sectors.
- Ignored inputs:
  - RD_ACK/RD_DONE outside their waiting state are ignored.
  - RD_ACK and RD_DONE in the same cycle: only RD_ACK is honoured.
- SPI_INIT=1 in any state: next cycle state IDLE, RD_REQ=0, WALK_ERR=0, no pop, PIC_DONE not pulsed. Overrides every other event in that cycle.
- BPB_VALID falling mid-walk: treated like SPI_INIT.
- NEXT_PIC outside DONE is ignored.

Decomposition:
- Shared package sdrd_fat32_pkg:
  - RD_TYPE encodings (BPB 00, DIR 01, FAT 10, DATA 11).
  - FAT32 constants: CLUS_MASK 0x0FFFFFFF, EOC_MIN 0x0FFFFFF8, BAD_CLUS 0x0FFFFFF7, FIRST_DATA_CLUS 2.
  - State encoding.
- One sub-module, sdrd_clus2lba: combinational data LBA and FAT LBA/offset computation. Shared later with the directory controller.

Test Plan:
- Single-cluster file: CLUS_BEGIN=0x2000, SPC_LOG2=2, entry 5, FAT word 0x0FFFFFFF -> data RD_ADR 0x200C..0x200F, then FAT RD_ADR=FAT_BEGIN+0, RD_OFS=5, then PIC_DONE, one PICENTRY_RD.
- Chain crossing FAT sectors: entry 0x7F -> FAT word 0x80 -> FAT word 0x0FFFFFF8 -> FAT reads at FAT_BEGIN+0 ofs 127, then FAT_BEGIN+1 ofs 0; data LBAs continuous per cluster.
- Backpressure: DATABUF_AFULL=1 for 50 cycles in DATA_REQ -> RD_REQ stays 0; RD_REQ rises the cycle after AFULL falls; RD_ADR stable while RD_ACK is withheld 10 cycles.
- Errors: FAT word 0x00000001 -> WALK_ERR=1 and no further RD_REQ; separately, no RD_DONE for TIMEOUT_CYC (set to 100) -> WALK_ERR.
- SPI_INIT pulse during DATA_WAIT -> IDLE next cycle, RD_REQ=0, no PIC_DONE; walk restarts from a new FIFO entry after BPB_VALID.
- Empty file: entry 0x0FFFFFFF -> PIC_DONE with zero RD_REQ; NEXT_PIC pops the next entry.
